instr_assembler: RTL
====================

INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
REQ-001 Parameter BUS_W, default 8, fetch bus width in bits (>=1).
REQ-002 Parameter NUM_BEATS, default 2, beats per instruction (>=2).
REQ-003 Parameter MSB_FIRST, default 1; 1 = first beat is most-significant, 0 = first beat is least-significant.
REQ-004 Parameter ABORT_ON_GAP, default 1; 1 = in_valid low during COLLECT aborts the instruction, 0 = collection pauses.
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  synchronous discard of partial/held instruction.
REQ-008 in_valid  input  1  beat present on data.
REQ-009 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-010 data  input  BUS_W  fetch beat.
REQ-011 out_valid  output  1  assembled instruction available.
REQ-012 out_ready  input  1  consumer takes instruction when out_valid && out_ready.
REQ-013 instr_out  output  BUS_W*NUM_BEATS  assembled instruction, registered.
REQ-014 beat_cnt  output  clog2(NUM_BEATS)  index of next beat slot.

Function
REQ-015 States SHALL be IDLE, COLLECT, HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and COLLECT, and equal out_ready in HOLD (combinational).
REQ-017 Accepted beat k (0-based) SHALL be written to slot NUM_BEATS-1-k when MSB_FIRST=1, slot k when MSB_FIRST=0; slot j = instr_out[j*BUS_W +: BUS_W].
REQ-018 IDLE: accepted beat -> slot for k=0, beat_cnt=1, go COLLECT.
REQ-019 COLLECT: accepted beat increments beat_cnt; beat NUM_BEATS-1 -> beat_cnt=0, out_valid=1 next cycle, go HOLD.
REQ-020 Latency: out_valid SHALL rise the cycle after the last beat is accepted.
REQ-021 COLLECT with in_valid=0 and ABORT_ON_GAP=1: beat_cnt=0, go IDLE, no out_valid; already-written slots keep stale values.
REQ-022 COLLECT with in_valid=0 and ABORT_ON_GAP=0: hold state and beat_cnt.
REQ-023 HOLD: instr_out and out_valid SHALL be stable until out_ready=1.
REQ-024 HOLD with out_ready=1 and no beat: out_valid=0, go IDLE.
REQ-025 HOLD with out_ready=1 and accepted beat: out_valid=0, beat written as beat 0, beat_cnt=1, go COLLECT (back-to-back, no bubble).
REQ-026 flush=1 SHALL override all else: out_valid=0, beat_cnt=0, go IDLE, concurrent beat discarded; instr_out unchanged.
REQ-027 Throughput SHALL be one instruction per NUM_BEATS cycles with continuous in_valid and out_ready.

Reset
REQ-028 Reset SHALL force state IDLE, beat_cnt=0, out_valid=0, instr_out=0 (and out_err=0 when compiled in), immediately and independent of clk.
REQ-029 Reset mid-collection or in HOLD SHALL discard the instruction; first accepted beat after release is beat 0.

Configuration
REQ-030 Macro INSTR_ASSEMBLER_PARITY_EN defined: add input data_par (1, odd parity over data) and output out_err (1); out_err SHALL be valid with out_valid, 1 if any beat of that instruction failed parity, cleared by reset, flush, abort, or start of next instruction.
REQ-031 Macro undefined: data_par and out_err ports and parity logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 State encoding typedef (IDLE/COLLECT/HOLD) and slot-index helper function SHALL live in shared package cpu_fetch_pkg.
REQ-033 Optional sub-module beat_parity_chk (combinational odd-parity check), instantiated only under INSTR_ASSEMBLER_PARITY_EN.

Verification
REQ-034 Defaults, beats 0xA5,0x3C consecutive, out_ready=1 -> instr_out=0xA53C, out_valid high one cycle, 2 cycles after first beat.
REQ-035 MSB_FIRST=0, NUM_BEATS=4, beats 0x11,0x22,0x33,0x44 -> instr_out=0x44332211.
REQ-036 Defaults, beat 0x12, gap, beats 0x34,0x56 -> single instruction 0x3456, no output for 0x12; ABORT_ON_GAP=0 same stimulus -> 0x1234.
REQ-037 HOLD with out_ready=0 for 5 cycles -> in_ready=0, instr_out stable; out_ready=1 with beat 0x77 -> handoff and beat_cnt=1 same edge.
REQ-038 flush during beat 1, and rst asserted in HOLD -> out_valid=0, beat_cnt=0; rst also zeroes instr_out.
REQ-039 PARITY_EN: beat with wrong data_par -> out_err=1 with out_valid; next clean instruction -> out_err=0.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path definitions: assembler state encoding and the beat-to-slot mapping.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    // Slot j occupies instr[j*BUS_W +: BUS_W]; beat 0 lands at the top when msb_first is set.
    function automatic int unsigned slot_index(input int unsigned beat,
                                               input int unsigned num_beats,
                                               input bit          msb_first);
        return msb_first ? (num_beats - 1 - beat) : beat;
    endfunction

endpackage

// File: rtl/beat_parity_chk.sv
// Combinational odd-parity check of one fetch beat: err=1 when data plus par has an even number of ones.
module beat_parity_chk #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         par,
    output logic         err
);

    assign err = ~(^{data, par});

endmodule

// File: rtl/instr_assembler.sv
// Packs NUM_BEATS fetch beats of BUS_W bits into one registered instruction word.
// Optional beat parity checking is compiled in with INSTR_ASSEMBLER_PARITY_EN.
module instr_assembler
    import cpu_fetch_pkg::*;
#(
    parameter int BUS_W        = 8,
    parameter int NUM_BEATS    = 2,
    parameter int MSB_FIRST    = 1,
    parameter int ABORT_ON_GAP = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BUS_W-1:0]             data,
`ifdef INSTR_ASSEMBLER_PARITY_EN
    input  logic                         data_par,
    output logic                         out_err,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BUS_W*NUM_BEATS-1:0]   instr_out,
    output logic [$clog2(NUM_BEATS)-1:0] beat_cnt
);

    localparam int CNT_W = $clog2(NUM_BEATS);

    asm_state_t         state;
    logic [CNT_W-1:0]   wr_beat;
    int unsigned        wr_lsb;
    logic               last_beat;

    assign in_ready  = (state == HOLD) ? out_ready : 1'b1;
    assign last_beat = (beat_cnt == CNT_W'(NUM_BEATS - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_beat = '0;
        if (state == COLLECT)
            wr_beat = beat_cnt;
        wr_lsb = slot_index(32'(wr_beat), NUM_BEATS, MSB_FIRST != 0) * BUS_W;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            instr_out <= '0;
        end else if (flush) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        instr_out[wr_lsb +: BUS_W] <= data;
                        beat_cnt                   <= CNT_W'(1);
                        state                      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        instr_out[wr_lsb +: BUS_W] <= data;
                        if (last_beat) begin
                            beat_cnt  <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end else if (ABORT_ON_GAP != 0) begin
                        // Slots already written keep their stale contents.
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            instr_out[wr_lsb +: BUS_W] <= data;
                            beat_cnt                   <= CNT_W'(1);
                            state                      <= COLLECT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

`ifdef INSTR_ASSEMBLER_PARITY_EN
    logic beat_err;
    logic start_instr;
    logic cont_beat;
    logic abort_instr;

    beat_parity_chk #(.W(BUS_W)) u_par_chk (
        .data (data),
        .par  (data_par),
        .err  (beat_err)
    );

    assign start_instr = in_valid && in_ready && (state != COLLECT);
    assign cont_beat   = in_valid && (state == COLLECT);
    assign abort_instr = !in_valid && (state == COLLECT) && (ABORT_ON_GAP != 0);

    // Sticky across the beats of one instruction, restarted by its first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_err <= 1'b0;
        else if (flush || abort_instr)
            out_err <= 1'b0;
        else if (start_instr)
            out_err <= beat_err;
        else if (cont_beat)
            out_err <= out_err | beat_err;
    end
`endif

endmodule
